// File: rtl/a51_pkg.sv
// Shared types and constants for the A5/1 keystream sequencer.
package a51_pkg;

  localparam int unsigned KEY_BITS    = 64;
  localparam int unsigned FRAME_BITS  = 22;
  localparam int unsigned WARM_CYCLES = 100;
  localparam int unsigned KS_BITS     = 228;
  localparam int unsigned WORD_W      = 32;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned BIT_W   = 8;
  localparam int unsigned POS_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_KEY,
    ST_FRAME,
    ST_WARM,
    ST_GEN,
    ST_FLUSH
  } a51_state_e;

endpackage

// File: rtl/a51_ks_packer.sv
// Packs keystream bits into words and holds one word on a valid/ready output.
module a51_ks_packer
  import a51_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              gen_en,
  input  logic              ks_bit,
  input  logic              ready,
  output logic              can_shift,
  output logic              bit_last,
  output logic              last_acc,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              last
);

  logic [WORD_W-1:0] pack_q;
  logic              pack_full_q;
  logic              pack_last_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              out_free;
  logic              completes;
  logic              is_last;
  logic [WORD_W-1:0] merged;

  // Capture is allowed unless a finished word is parked in the pack with no room downstream.
  always_comb begin
    out_free  = !valid || ready;
    can_shift = gen_en && (!pack_full_q || out_free);
    is_last   = (bit_cnt_q == BIT_W'(KS_BITS - 1));
    completes = can_shift && ((bit_cnt_q[POS_W-1:0] == '1) || is_last);
    bit_last  = can_shift && is_last;
    last_acc  = valid && ready && last;
    // A parked word leaves this cycle whenever a capture happens, so the new bit starts a fresh pack.
    merged    = (pack_full_q ? '0 : pack_q) | (WORD_W'(ks_bit) << bit_cnt_q[POS_W-1:0]);
  end

  // Pack register, bit counter and output register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pack_q      <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
      bit_cnt_q   <= '0;
      word        <= '0;
      valid       <= 1'b0;
      last        <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end
      if (pack_full_q && out_free) begin
        word        <= pack_q;
        valid       <= 1'b1;
        last        <= pack_last_q;
        pack_q      <= '0;
        pack_full_q <= 1'b0;
        pack_last_q <= 1'b0;
      end
      if (can_shift) begin
        if (!is_last) bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        if (completes) begin
          if (out_free) begin
            word   <= merged;
            valid  <= 1'b1;
            last   <= is_last;
            pack_q <= '0;
          end else begin
            pack_q      <= merged;
            pack_full_q <= 1'b1;
            pack_last_q <= is_last;
          end
        end else begin
          pack_q <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/a51_keystream_sequencer.sv
// Drives one A5/1 session on the cipher core and streams the keystream as words.
module a51_keystream_sequencer
  import a51_pkg::*;
(
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [KEY_BITS-1:0]   key_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  core_clear_o,
  output logic                  core_shift_o,
  output logic                  core_maj_o,
  output logic                  core_mix_o,
  input  logic                  core_ks_i,
  output logic [WORD_W-1:0]     ks_word_o,
  output logic                  ks_valid_o,
  output logic                  ks_last_o,
  input  logic                  ks_ready_i
);

  a51_state_e            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q;
  logic [KEY_BITS-1:0]   key_q, key_sh;
  logic [FRAME_BITS-1:0] frame_q, frame_sh;
  logic                  start_acc;
  logic                  phase_step;
  logic                  can_shift, bit_last, last_acc;
  logic                  done_q;

  assign start_acc  = (state_q == ST_IDLE) && start_i && !abort_i;
  assign phase_step = (state_q == ST_KEY) || (state_q == ST_FRAME) || (state_q == ST_WARM);
  assign done_o     = done_q;

  // State register; abort has priority over everything except reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || abort_i) state_q <= ST_IDLE;
    else                     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_KEY;
      ST_KEY:   if (phase_q == PHASE_W'(KEY_BITS - 1))    state_d = ST_FRAME;
      ST_FRAME: if (phase_q == PHASE_W'(FRAME_BITS - 1))  state_d = ST_WARM;
      ST_WARM:  if (phase_q == PHASE_W'(WARM_CYCLES - 1)) state_d = ST_GEN;
      ST_GEN:   if (bit_last) state_d = ST_FLUSH;
      ST_FLUSH: if (last_acc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; the core never shifts on an abort or reset cycle.
  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    core_clear_o = (state_q == ST_CLEAR);
    core_shift_o = 1'b0;
    core_maj_o   = 1'b0;
    core_mix_o   = 1'b0;
    key_sh       = key_q >> phase_q;
    frame_sh     = frame_q >> phase_q;
    case (state_q)
      ST_KEY: begin
        core_shift_o = 1'b1;
        core_mix_o   = key_sh[0];
      end
      ST_FRAME: begin
        core_shift_o = 1'b1;
        core_mix_o   = frame_sh[0];
      end
      ST_WARM: begin
        core_shift_o = 1'b1;
        core_maj_o   = 1'b1;
      end
      ST_GEN: begin
        core_shift_o = can_shift;
        core_maj_o   = 1'b1;
      end
      default: ;
    endcase
    if (abort_i || wb_rst_i) core_shift_o = 1'b0;
  end

  // Phase counter restarts on every state change and only counts in timed phases.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || abort_i || (state_d != state_q)) phase_q <= '0;
    else if (phase_step)                             phase_q <= phase_q + PHASE_W'(1);
  end

  // Key/frame latch on session accept.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_q   <= '0;
      frame_q <= '0;
    end else if (start_acc) begin
      key_q   <= key_i;
      frame_q <= frame_i;
    end
  end

  // Done pulses the cycle after the final word is taken.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) done_q <= 1'b0;
    else          done_q <= !abort_i && (state_q == ST_FLUSH) && last_acc;
  end

  a51_ks_packer u_packer (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clr       (abort_i || start_acc),
    .gen_en    (state_q == ST_GEN),
    .ks_bit    (core_ks_i),
    .ready     (ks_ready_i),
    .can_shift (can_shift),
    .bit_last  (bit_last),
    .last_acc  (last_acc),
    .word      (ks_word_o),
    .valid     (ks_valid_o),
    .last      (ks_last_o)
  );

endmodule
